shift_reg_ctrl: RTL and testbench

- Tick-driven parallel shift register that consumes the slow `tick_en` square wave from the clock-enable stage.
- Each qualifying tick edge advances the register one position: shift, rotate or bounce ("knight rider").
- Sits between the clock-enable generator and the board LED / serial-out pins.
- Supports synchronous parallel load and hold.

---
 rtl/shift_reg_ctrl.sv | 114 +++++++++++
 tb/tb_shift_reg_ctrl.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/shift_reg_ctrl.sv
// Tick-driven parallel shift register: shift, rotate or bounce on each qualifying
// tick_en edge, with synchronous parallel load and hold.
module shift_reg_ctrl #(
   parameter int unsigned     WIDTH      = 8,
   parameter logic [WIDTH-1:0] INIT      = {{(WIDTH-1){1'b0}}, 1'b1},
   parameter bit              BOTH_EDGES = 1'b0
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             tick_en,
   input  logic [1:0]       mode,
   input  logic             serial_in,
   input  logic             load,
   input  logic [WIDTH-1:0] load_data,
   input  logic             hold,
   output logic [WIDTH-1:0] q,
   output logic             dir,
   output logic             step,
   output logic             wrap
);

   typedef enum logic {
      LEFT  = 1'b0,
      RIGHT = 1'b1
   } dir_t;

   localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

   logic [WIDTH-1:0] q_q, q_nx;
   dir_t             dir_q, dir_nx;
   logic             step_q, step_nx;
   logic             wrap_q, wrap_nx;
   logic             tick_q;
   logic             rise, fall, adv;

   assign rise = tick_en & ~tick_q;
   assign fall = ~tick_en & tick_q;
   assign adv  = rise | (BOTH_EDGES & fall);

   // tick_q resets high so a tick_en already high at release is not an edge
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         q_q    <= INIT;
         dir_q  <= LEFT;
         step_q <= 1'b0;
         wrap_q <= 1'b0;
         tick_q <= 1'b1;
      end else begin
         q_q    <= q_nx;
         dir_q  <= dir_nx;
         step_q <= step_nx;
         wrap_q <= wrap_nx;
         tick_q <= tick_en;
      end
   end

   always_comb begin
      q_nx    = q_q;
      dir_nx  = (mode == 2'b11) ? dir_q : LEFT;
      step_nx = 1'b0;
      wrap_nx = 1'b0;
      if (load) begin
         q_nx   = load_data;
         dir_nx = LEFT;
      end else if (hold) begin
         q_nx = q_q;
      end else if (adv) begin
         step_nx = 1'b1;
         unique case (mode)
            2'b00: begin
               q_nx    = {q_q[WIDTH-2:0], serial_in};
               wrap_nx = q_q[WIDTH-1];
            end
            2'b01: begin
               q_nx    = {serial_in, q_q[WIDTH-1:1]};
               wrap_nx = q_q[0];
            end
            2'b10: begin
               q_nx    = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
               wrap_nx = q_q[WIDTH-1];
            end
            default: begin
               // an empty register would bounce forever without lighting anything
               if (q_q == '0) begin
                  q_nx   = ONE;
                  dir_nx = LEFT;
               end else if (dir_q == LEFT) begin
                  if (q_q[WIDTH-1]) begin
                     dir_nx  = RIGHT;
                     q_nx    = q_q >> 1;
                     wrap_nx = 1'b1;
                  end else begin
                     q_nx = q_q << 1;
                  end
               end else begin
                  if (q_q[0]) begin
                     dir_nx  = LEFT;
                     q_nx    = q_q << 1;
                     wrap_nx = 1'b1;
                  end else begin
                     q_nx = q_q >> 1;
                  end
               end
            end
         endcase
      end
   end

   assign q    = q_q;
   assign dir  = dir_q;
   assign step = step_q;
   assign wrap = wrap_q;

endmodule

// File: tb/tb_shift_reg_ctrl.sv
// Directed, table-driven bench for shift_reg_ctrl: one instance per edge mode.
module tb_shift_reg_ctrl;

   logic       clk = 1'b0;
   logic       rstn;
   logic       tick_en;
   logic [1:0] mode;
   logic       serial_in;
   logic       load;
   logic [7:0] load_data;
   logic       hold;

   logic [7:0] q0, q1;
   logic       dir0, dir1, step0, step1, wrap0, wrap1;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   always #5 clk = ~clk;

   shift_reg_ctrl #(.WIDTH(8), .INIT(8'h01), .BOTH_EDGES(1'b0)) dut0 (
      .clk(clk), .rstn(rstn), .tick_en(tick_en), .mode(mode), .serial_in(serial_in),
      .load(load), .load_data(load_data), .hold(hold),
      .q(q0), .dir(dir0), .step(step0), .wrap(wrap0)
   );

   shift_reg_ctrl #(.WIDTH(8), .INIT(8'h01), .BOTH_EDGES(1'b1)) dut1 (
      .clk(clk), .rstn(rstn), .tick_en(tick_en), .mode(mode), .serial_in(serial_in),
      .load(load), .load_data(load_data), .hold(hold),
      .q(q1), .dir(dir1), .step(step1), .wrap(wrap1)
   );

   typedef struct {
      logic [1:0] mode;
      logic       sin;
      logic       ld;
      logic [7:0] ld_data;
      logic       hold;
      logic [7:0] q;
      logic       dir;
      logic       step;
      logic       wrap;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic [1:0] m, input logic s, input logic l, input logic [7:0] d,
                      input logic h, input logic [7:0] eq, input logic ed, input logic es,
                      input logic ew);
      vec_t v;
      v.mode = m; v.sin = s; v.ld = l; v.ld_data = d; v.hold = h;
      v.q = eq; v.dir = ed; v.step = es; v.wrap = ew;
      vecs.push_back(v);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   int unsigned sc0, sc1;

   initial begin
      rstn = 1'b0; tick_en = 1'b1; mode = 2'b10; serial_in = 1'b0;
      load = 1'b0; load_data = 8'h00; hold = 1'b0;

      // mode shl/shr/rotl/bounce rows; each row is one full tick period ending on a rising edge
      for (int i = 1; i <= 8; i++)
         add(2'b10, 0, 0, 8'h00, 0, 8'(1 << (i % 8)), 0, 1, (i == 8));
      add(2'b11, 0, 0, 8'h00, 0, 8'h02, 0, 1, 0);
      add(2'b11, 0, 0, 8'h00, 0, 8'h04, 0, 1, 0);
      add(2'b11, 0, 0, 8'h00, 0, 8'h08, 0, 1, 0);
      add(2'b11, 0, 0, 8'h00, 0, 8'h10, 0, 1, 0);
      add(2'b11, 0, 0, 8'h00, 0, 8'h20, 0, 1, 0);
      add(2'b11, 0, 0, 8'h00, 0, 8'h40, 0, 1, 0);
      add(2'b11, 0, 0, 8'h00, 0, 8'h80, 0, 1, 0);
      add(2'b11, 0, 0, 8'h00, 0, 8'h40, 1, 1, 1);
      add(2'b11, 0, 0, 8'h00, 0, 8'h20, 1, 1, 0);
      add(2'b11, 0, 0, 8'h00, 0, 8'h10, 1, 1, 0);
      add(2'b11, 0, 0, 8'h00, 0, 8'h08, 1, 1, 0);
      add(2'b11, 0, 0, 8'h00, 0, 8'h04, 1, 1, 0);
      add(2'b11, 0, 0, 8'h00, 0, 8'h02, 1, 1, 0);
      add(2'b11, 0, 0, 8'h00, 0, 8'h01, 1, 1, 0);
      add(2'b11, 0, 0, 8'h00, 0, 8'h02, 0, 1, 1);
      add(2'b00, 1, 1, 8'h81, 0, 8'h81, 0, 0, 0);
      add(2'b00, 1, 0, 8'h00, 0, 8'h03, 0, 1, 1);
      add(2'b01, 0, 0, 8'h00, 0, 8'h01, 0, 1, 1);
      add(2'b01, 0, 1, 8'hA5, 0, 8'hA5, 0, 0, 0);
      add(2'b01, 0, 0, 8'h00, 1, 8'hA5, 0, 0, 0);
      add(2'b01, 0, 0, 8'h00, 1, 8'hA5, 0, 0, 0);
      add(2'b01, 0, 0, 8'h00, 1, 8'hA5, 0, 0, 0);
      add(2'b01, 0, 0, 8'h00, 0, 8'h52, 0, 1, 1);
      add(2'b11, 0, 1, 8'h00, 0, 8'h00, 0, 0, 0);
      add(2'b11, 0, 0, 8'h00, 0, 8'h01, 0, 1, 0);
      add(2'b10, 0, 0, 8'h00, 0, 8'h02, 0, 1, 0);

      // reset held with tick_en high
      repeat (2) cyc();
      check("rst_q", 32'(q0), 32'h01);
      check("rst_dir", 32'(dir0), 0);
      check("rst_step", 32'(step0), 0);
      check("rst_wrap", 32'(wrap0), 0);
      rstn = 1'b1;
      repeat (2) cyc();
      check("rel_q", 32'(q0), 32'h01);
      check("rel_step", 32'(step0), 0);

      foreach (vecs[i]) begin
         mode = vecs[i].mode; serial_in = vecs[i].sin; load = vecs[i].ld;
         load_data = vecs[i].ld_data; hold = vecs[i].hold;
         tick_en = 1'b0;
         cyc();
         check($sformatf("v%0d_fall_step", i), 32'(step0), 0);
         tick_en = 1'b1;
         cyc();
         check($sformatf("v%0d_q", i), 32'(q0), 32'(vecs[i].q));
         check($sformatf("v%0d_dir", i), 32'(dir0), 32'(vecs[i].dir));
         check($sformatf("v%0d_step", i), 32'(step0), 32'(vecs[i].step));
         check($sformatf("v%0d_wrap", i), 32'(wrap0), 32'(vecs[i].wrap));
      end
      load = 1'b0; hold = 1'b0;

      // tick_en stays high: no further advance after the last edge
      cyc();
      check("steady_q", 32'(q0), 32'h02);
      check("steady_step", 32'(step0), 0);

      // asynchronous reset mid-run, tick_en high
      #2 rstn = 1'b0;
      #1;
      check("async_q", 32'(q0), 32'h01);
      check("async_step", 32'(step0), 0);
      cyc();
      rstn = 1'b1;
      repeat (3) cyc();
      check("post_rst_q", 32'(q0), 32'h01);
      check("post_rst_step", 32'(step0), 0);
      tick_en = 1'b0;
      cyc();
      check("post_rst_fall_q", 32'(q0), 32'h01);
      tick_en = 1'b1;
      cyc();
      check("post_rst_adv_q", 32'(q0), 32'h02);
      check("post_rst_adv_step", 32'(step0), 1);

      // both-edge instance: one tick period gives two steps
      load = 1'b1; load_data = 8'h01;
      repeat (2) cyc();
      load = 1'b0; mode = 2'b10;
      sc0 = 0; sc1 = 0;
      for (int c = 0; c < 4; c++) begin
         tick_en = (c >= 2);
         cyc();
         sc0 += 32'(step0);
         sc1 += 32'(step1);
         if (c == 0) begin
            check("be_fall_q", 32'(q1), 32'h02);
            check("be_fall_step", 32'(step1), 1);
         end
      end
      check("be_steps", sc1, 2);
      check("se_steps", sc0, 1);
      check("be_q", 32'(q1), 32'h04);
      check("se_q", 32'(q0), 32'h02);
      check("be_wrap", 32'(wrap1), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
